// File: rtl/axi_rr_stream_mux.sv
// N:1 valid/ready stream mux with round-robin arbitration, burst locking until
// the beat carrying last, and a registered output stage.
module axi_rr_stream_mux #(
    parameter  int unsigned NUM_IN = 2,
    parameter  int unsigned WIDTH  = 32,
    localparam int unsigned SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN-1:0]       in_last,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_grant;
    logic [SEL_W-1:0] w_grant_nxt;
    logic [SEL_W-1:0] r_rr_ptr;
    logic [SEL_W-1:0] w_rr_ptr_nxt;

    logic [SEL_W-1:0] w_pick;
    logic             w_any_valid;
    int unsigned      w_best;

    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_valid;
    logic             w_sel_last;
    logic             w_slot_free;
    logic             w_xfer;

    logic             r_out_valid;
    logic             r_out_last;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_sel;

    // Output register can accept a beat when empty or draining this cycle.
    assign w_slot_free = !r_out_valid || out_ready;

    // Round-robin pick: the valid source at the smallest wrapped distance from rr_ptr.
    always_comb begin
        w_pick      = '0;
        w_any_valid = 1'b0;
        w_best      = NUM_IN;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (in_valid[i] && (((i + NUM_IN - 32'(r_rr_ptr)) % NUM_IN) < w_best)) begin
                w_best      = (i + NUM_IN - 32'(r_rr_ptr)) % NUM_IN;
                w_pick      = SEL_W'(i);
                w_any_valid = 1'b1;
            end
        end
    end

    // Select the granted source; ungranted slices never reach the datapath.
    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (r_grant == SEL_W'(i)) begin
                w_sel_data  = in_data[i*WIDTH +: WIDTH];
                w_sel_valid = in_valid[i];
                w_sel_last  = in_last[i];
            end
        end
    end

    // Arbitration FSM next-state and ready generation.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        in_ready     = '0;
        w_xfer       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_valid) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                for (int unsigned i = 0; i < NUM_IN; i++) begin
                    if (r_grant == SEL_W'(i)) begin
                        in_ready[i] = w_slot_free;
                    end
                end
                w_xfer = w_sel_valid && w_slot_free;
                if (w_xfer && w_sel_last) begin
                    w_rr_ptr_nxt = (r_grant == SEL_W'(NUM_IN - 1)) ? '0 : (r_grant + SEL_W'(1));
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state, grant and round-robin pointer registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // Output register: load on transfer, otherwise clear valid when drained.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_sel_last;
            r_out_data  <= w_sel_data;
            r_out_sel   <= r_grant;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_axi_rr_stream_mux.sv
// Self-checking bench for axi_rr_stream_mux: table vectors, directed corner
// sequences, and randomized traffic against a transaction-level reference model.
module tb_axi_rr_stream_mux;

    localparam int unsigned N = 4;
    localparam int unsigned W = 32;

    logic           ACLK = 1'b0;
    logic           ARESETN;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_last;
    logic [1:0]     out_sel;
    logic           out_ready;

    logic [7:0]     s_in_data;
    logic [0:0]     s_in_valid;
    logic [0:0]     s_in_last;
    logic [0:0]     s_in_ready;
    logic [7:0]     s_out_data;
    logic           s_out_valid;
    logic           s_out_last;
    logic [0:0]     s_out_sel;
    logic           s_out_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 ACLK = ~ACLK;

    axi_rr_stream_mux #(.NUM_IN(4), .WIDTH(32)) u_dut4 (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_sel(out_sel), .out_ready(out_ready)
    );

    axi_rr_stream_mux #(.NUM_IN(1), .WIDTH(8)) u_dut1 (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .in_data(s_in_data), .in_valid(s_in_valid), .in_last(s_in_last), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_last(s_out_last),
        .out_sel(s_out_sel), .out_ready(s_out_ready)
    );

    typedef struct {
        logic [3:0]   valid;
        logic [3:0]   last;
        logic [127:0] data;
        logic [3:0]   exp_ready;
        logic         exp_ov;
        logic [31:0]  exp_od;
        logic         exp_ol;
        logic [1:0]   exp_os;
    } vec_t;

    vec_t tbl[10];

    // Reference model state (transaction level).
    int          m_owner;
    int          m_ptr;
    logic        m_ov;
    logic        m_ol;
    logic [31:0] m_od;
    int          m_os;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [3:0] v, input logic [3:0] l, input logic [127:0] d,
                                 input logic [3:0] er, input logic eov, input logic [31:0] eod,
                                 input logic eol, input logic [1:0] eos);
        vec_t r;
        r.valid = v; r.last = l; r.data = d; r.exp_ready = er;
        r.exp_ov = eov; r.exp_od = eod; r.exp_ol = eol; r.exp_os = eos;
        return r;
    endfunction

    task automatic drive_idle();
        in_valid    = '0;
        in_last     = '0;
        in_data     = '0;
        out_ready   = 1'b1;
        s_in_valid  = '0;
        s_in_last   = '0;
        s_in_data   = '0;
        s_out_ready = 1'b1;
    endtask

    task automatic apply_reset();
        ARESETN = 1'b0;
        drive_idle();
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    // First valid source searching upward from ptr with wrap.
    function automatic int rr_pick(input int ptr, input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (ptr + k) % 4;
            if (v[2'(i)]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready(input logic ordy);
        if (m_owner >= 0 && (!m_ov || ordy)) return 4'(1 << m_owner);
        return 4'b0000;
    endfunction

    task automatic model_step(input logic [3:0] v, input logic [3:0] l, input logic [127:0] d,
                              input logic ordy);
        logic free;
        int   p;
        free = !m_ov || ordy;
        if (m_owner < 0) begin
            if (m_ov && ordy) m_ov = 1'b0;
            p = rr_pick(m_ptr, v);
            if (p >= 0) m_owner = p;
        end else if (v[2'(m_owner)] && free) begin
            m_ov = 1'b1;
            m_od = d[m_owner*32 +: 32];
            m_ol = l[2'(m_owner)];
            m_os = m_owner;
            if (m_ol) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] got[$];
        logic [31:0] held;
        int          beat;
        logic        hs;
        logic [3:0]  rv;
        logic [3:0]  rl;
        logic [127:0] rd;
        logic        ro;
        logic [3:0]  er;

        held = '0;
        // Source 2 three-beat burst, then a check of the advanced rr pointer (3) and wrap to 0.
        tbl[0] = mkv(4'b0100, 4'b0000, {32'h0, 32'hA0, 32'h0, 32'h0}, 4'b0000, 1'b0, 32'h0,  1'b0, 2'd0);
        tbl[1] = mkv(4'b0100, 4'b0000, {32'h0, 32'hA0, 32'h0, 32'h0}, 4'b0100, 1'b1, 32'hA0, 1'b0, 2'd2);
        tbl[2] = mkv(4'b0100, 4'b0000, {32'h0, 32'hA1, 32'h0, 32'h0}, 4'b0100, 1'b1, 32'hA1, 1'b0, 2'd2);
        tbl[3] = mkv(4'b0100, 4'b0100, {32'h0, 32'hA2, 32'h0, 32'h0}, 4'b0100, 1'b1, 32'hA2, 1'b1, 2'd2);
        tbl[4] = mkv(4'b0000, 4'b0000, 128'h0,                        4'b0000, 1'b0, 32'h0,  1'b0, 2'd0);
        tbl[5] = mkv(4'b1001, 4'b1001, {32'hB3, 32'h0, 32'h0, 32'hB0}, 4'b0000, 1'b0, 32'h0,  1'b0, 2'd0);
        tbl[6] = mkv(4'b1001, 4'b1001, {32'hB3, 32'h0, 32'h0, 32'hB0}, 4'b1000, 1'b1, 32'hB3, 1'b1, 2'd3);
        tbl[7] = mkv(4'b1001, 4'b1001, {32'hB3, 32'h0, 32'h0, 32'hB0}, 4'b0000, 1'b0, 32'h0,  1'b0, 2'd0);
        tbl[8] = mkv(4'b1001, 4'b1001, {32'hB3, 32'h0, 32'h0, 32'hB0}, 4'b0001, 1'b1, 32'hB0, 1'b1, 2'd0);
        tbl[9] = mkv(4'b0000, 4'b0000, 128'h0,                        4'b0000, 1'b0, 32'h0,  1'b0, 2'd0);

        // Reset state.
        ARESETN = 1'b0;
        drive_idle();
        #1;
        chk("rst_out4", {out_valid, out_last, out_sel, out_data}, 64'h0);
        chk("rst_ready4", 64'(in_ready), 64'h0);
        chk("rst_out1", {s_out_valid, s_out_last, s_out_sel, s_out_data}, 64'h0);
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;

        // Table-driven vectors.
        for (int r = 0; r < 10; r++) begin
            @(negedge ACLK);
            in_valid = tbl[r].valid;
            in_last  = tbl[r].last;
            in_data  = tbl[r].data;
            #1;
            chk($sformatf("tbl%0d_ready", r), 64'(in_ready), 64'(tbl[r].exp_ready));
            @(posedge ACLK);
            #1;
            chk($sformatf("tbl%0d_ov", r), 64'(out_valid), 64'(tbl[r].exp_ov));
            if (tbl[r].exp_ov)
                chk($sformatf("tbl%0d_beat", r), {out_data, out_last, out_sel},
                    {tbl[r].exp_od, tbl[r].exp_ol, tbl[r].exp_os});
        end

        // All four sources valid with single-beat bursts: grant order 0,1,2,3,0, one gap cycle each.
        apply_reset();
        in_valid = 4'hF;
        in_last  = 4'hF;
        in_data  = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        for (int k = 0; k < 10; k++) begin
            @(posedge ACLK);
            #1;
            chk($sformatf("rr%0d_ov", k), 64'(out_valid), 64'(k % 2));
            if (k % 2 == 1)
                chk($sformatf("rr%0d_beat", k), {out_data, out_sel},
                    {32'hC0 + 32'(((k - 1) / 2) % 4), 2'(((k - 1) / 2) % 4)});
        end

        // Source 1 four-beat burst; source 0 requests mid-burst and must wait.
        apply_reset();
        for (int e = 0; e < 7; e++) begin
            @(negedge ACLK);
            in_valid[1] = (e <= 4);
            in_last[1]  = (e == 4);
            in_data[32 +: 32] = 32'hD0 + 32'((e == 0) ? 0 : e - 1);
            in_valid[0] = (e >= 2);
            in_last[0]  = 1'b1;
            in_data[0 +: 32] = 32'hE0;
            #1;
            if (e == 0 || e == 5)  er = 4'b0000;
            else if (e == 6)       er = 4'b0001;
            else                   er = 4'b0010;
            chk($sformatf("lock%0d_ready", e), 64'(in_ready), 64'(er));
            @(posedge ACLK);
            #1;
            if (e >= 1 && e <= 4) begin
                chk($sformatf("lock%0d_beat", e), {out_valid, out_data, out_last, out_sel},
                    {1'b1, 32'hD0 + 32'(e - 1), (e == 4), 2'd1});
            end else if (e == 6) begin
                chk("lock6_beat", {out_valid, out_data, out_last, out_sel}, {1'b1, 32'hE0, 1'b1, 2'd0});
            end else begin
                chk($sformatf("lock%0d_ov", e), 64'(out_valid), 64'h0);
            end
        end

        // Source 3 six-beat burst with out_ready low for five cycles.
        apply_reset();
        beat = 0;
        got.delete();
        for (int c = 0; c < 25; c++) begin
            @(negedge ACLK);
            out_ready = !(c >= 4 && c < 9);
            in_valid  = (beat < 6) ? 4'b1000 : 4'b0000;
            in_last   = (beat == 5) ? 4'b1000 : 4'b0000;
            in_data[96 +: 32] = 32'hF0 + 32'(beat);
            #1;
            if (c >= 4 && c < 9) begin
                chk($sformatf("stall%0d_ov", c), 64'(out_valid), 64'h1);
                chk($sformatf("stall%0d_ready3", c), 64'(in_ready[3]), 64'h0);
                if (c == 4) held = out_data;
                else        chk($sformatf("stall%0d_data", c), 64'(out_data), 64'(held));
            end
            hs = in_valid[3] && in_ready[3];
            if (out_valid && out_ready) got.push_back(out_data);
            @(posedge ACLK);
            #1;
            if (hs) beat++;
        end
        chk("stall_held", 64'(held), 64'hF2);
        chk("stall_count", 64'(got.size()), 64'd6);
        for (int i = 0; i < got.size(); i++)
            chk($sformatf("stall_beat%0d", i), 64'(got[i]), 64'(32'hF0 + 32'(i)));

        // Asynchronous reset mid-burst; next arbitration starts from pointer 0.
        apply_reset();
        in_valid = 4'b0010;
        in_last  = 4'b0010;
        in_data  = {32'h0, 32'h0, 32'h51, 32'h0};
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        in_valid = 4'b0100;
        in_last  = 4'b0000;
        in_data  = {32'h0, 32'h55, 32'h0, 32'h0};
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        #1;
        chk("arst_pre_ov", 64'(out_valid), 64'h1);
        #1;
        ARESETN = 1'b0;
        #1;
        chk("arst_ov", 64'(out_valid), 64'h0);
        chk("arst_ready", 64'(in_ready), 64'h0);
        #1;
        ARESETN  = 1'b1;
        in_valid = 4'b1010;
        in_last  = 4'b1010;
        in_data  = {32'h63, 32'h0, 32'h61, 32'h0};
        @(posedge ACLK);
        #1;
        chk("arst_e0_ov", 64'(out_valid), 64'h0);
        @(posedge ACLK);
        #1;
        chk("arst_e1_beat", {out_valid, out_data, out_last, out_sel}, {1'b1, 32'h61, 1'b1, 2'd1});

        // Single-source instance: two-beat burst.
        drive_idle();
        @(negedge ACLK);
        s_in_valid = 1'b1; s_in_last = 1'b0; s_in_data = 8'h11;
        #1;
        chk("one_ready0", 64'(s_in_ready), 64'h0);
        @(posedge ACLK);
        #1;
        chk("one_ov0", 64'(s_out_valid), 64'h0);
        @(negedge ACLK);
        #1;
        chk("one_ready1", 64'(s_in_ready), 64'h1);
        @(posedge ACLK);
        #1;
        chk("one_beat1", {s_out_valid, s_out_data, s_out_last, s_out_sel}, {1'b1, 8'h11, 1'b0, 1'b0});
        @(negedge ACLK);
        s_in_data = 8'h22; s_in_last = 1'b1;
        @(posedge ACLK);
        #1;
        chk("one_beat2", {s_out_valid, s_out_data, s_out_last, s_out_sel}, {1'b1, 8'h22, 1'b1, 1'b0});
        @(negedge ACLK);
        s_in_valid = 1'b0; s_in_last = 1'b0;
        #1;
        chk("one_idle_ready", 64'(s_in_ready), 64'h0);
        @(posedge ACLK);
        #1;
        chk("one_drain_ov", 64'(s_out_valid), 64'h0);

        // Randomized traffic against the reference model.
        apply_reset();
        m_owner = -1; m_ptr = 0; m_ov = 1'b0; m_ol = 1'b0; m_od = '0; m_os = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge ACLK);
            rv = 4'($urandom);
            for (int i = 0; i < 4; i++) rl[i] = ($urandom_range(2) == 0);
            rd = {$urandom, $urandom, $urandom, $urandom};
            ro = ($urandom_range(3) != 0);
            in_valid  = rv;
            in_last   = rl;
            in_data   = rd;
            out_ready = ro;
            #1;
            chk($sformatf("rnd%0d_ready", cyc), 64'(in_ready), 64'(model_ready(ro)));
            model_step(rv, rl, rd, ro);
            @(posedge ACLK);
            #1;
            chk($sformatf("rnd%0d_ov", cyc), 64'(out_valid), 64'(m_ov));
            if (m_ov)
                chk($sformatf("rnd%0d_beat", cyc), {out_data, out_last, out_sel},
                    {m_od, m_ol, 2'(m_os)});
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
